// File: rtl/csdf_sched_pkg.sv
// Shared types and sizing helpers for the CSDF flux scheduler.
package csdf_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2
    } sched_state_e;

    function automatic int tag_width(input int flux);
        return (flux > 1) ? $clog2(flux) : 1;
    endfunction

    function automatic int set_cnt_width(input int num_op);
        return (num_op > 0) ? $clog2(num_op + 1) : 1;
    endfunction

    function automatic int rr_next(input int idx, input int flux);
        return (idx + 1 >= flux) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/csdf_flux_sched_rr_arbiter.sv
// Combinational round-robin pick: first ready flux at or after rr_ptr.
module rr_arbiter #(
    parameter int FLUX = 2,
    parameter int TW   = 1
) (
    input  logic [FLUX-1:0] ready,
    input  logic [TW-1:0]   rr_ptr,
    output logic [TW-1:0]   gnt_idx,
    output logic            valid
);

    int f;

    always_comb begin
        gnt_idx = '0;
        valid   = 1'b0;
        f       = 0;
        for (int k = 0; k < FLUX; k++) begin
            f = (int'(rr_ptr) + k) % FLUX;
            if (!valid && ready[f]) begin
                valid   = 1'b1;
                gnt_idx = TW'(f);
            end
        end
    end

endmodule

// File: rtl/csdf_flux_sched.sv
// Round-robin flux scheduler in front of a shared accumulating CSDF actor.
// Optional per-flux completed-burst counters: define CSDF_SCHED_STATS_EN.
//
// state | meaning
// IDLE  | arbitrating among ready fluxes
// GRANT | granted flux wired to actor, counting NUM_OP token sets
// DRAIN | inputs blocked, waiting for the tagged result of the granted flux
module csdf_flux_sched
    import csdf_sched_pkg::*;
#(
    parameter int PORTS  = 2,
    parameter int FLUX   = 2,
    parameter int WIDTH  = 8,
    parameter int NUM_OP = 4
) (
    input  logic                                       ck,
    input  logic                                       rst,
    input  logic [WIDTH*PORTS*FLUX-1:0]                in_data,
    input  logic [PORTS*FLUX-1:0]                      in_empty,
    output logic [PORTS*FLUX-1:0]                      in_read,
    output logic [WIDTH*PORTS-1:0]                     act_data,
    output logic [PORTS-1:0]                           act_empty,
    input  logic [PORTS-1:0]                           act_read,
    input  logic                                       act_wr,
    input  logic [WIDTH-1:0]                           act_out_data,
    output logic                                       act_full,
    input  logic [FLUX-1:0]                            out_full,
    output logic [FLUX-1:0]                            out_wr,
    output logic [(WIDTH-tag_width(FLUX))*FLUX-1:0]    out_data,
    output logic [tag_width(FLUX)-1:0]                 grant,
    output logic                                       busy
`ifdef CSDF_SCHED_STATS_EN
    ,
    output logic [16*FLUX-1:0]                         burst_cnt
`endif
);

    localparam int TAG_WIDTH = tag_width(FLUX);
    localparam int PW        = WIDTH - TAG_WIDTH;
    localparam int CW        = set_cnt_width(NUM_OP);

    sched_state_e         state, state_nxt;
    logic [TAG_WIDTH-1:0] grant_nxt, rr_ptr, rr_nxt, arb_idx, tag;
    logic [CW-1:0]        set_cnt, cnt_nxt;
    logic [FLUX-1:0]      ready;
    logic [PORTS-1:0]     cur_empty;
    logic                 arb_valid, drain_done, tag_ok;

    always_comb begin
        ready = '0;
        for (int f = 0; f < FLUX; f++)
            ready[f] = ~|in_empty[f*PORTS +: PORTS];
    end

    rr_arbiter #(.FLUX(FLUX), .TW(TAG_WIDTH)) u_arb (
        .ready   (ready),
        .rr_ptr  (rr_ptr),
        .gnt_idx (arb_idx),
        .valid   (arb_valid)
    );

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            grant   <= '0;
            rr_ptr  <= '0;
            set_cnt <= '0;
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            rr_ptr  <= rr_nxt;
            set_cnt <= cnt_nxt;
        end
    end

    assign tag    = act_out_data[WIDTH-1 -: TAG_WIDTH];
    assign tag_ok = int'(tag) < FLUX;

    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant;
        rr_nxt     = rr_ptr;
        cnt_nxt    = set_cnt;
        drain_done = 1'b0;
        in_read    = '0;
        act_empty  = '1;
        act_data   = in_data[int'(grant)*PORTS*WIDTH +: PORTS*WIDTH];
        cur_empty  = in_empty[int'(grant)*PORTS +: PORTS];
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    state_nxt = GRANT;
                    grant_nxt = arb_idx;
                    cnt_nxt   = '0;
                end
            end
            GRANT: begin
                act_empty = cur_empty;
                in_read[int'(grant)*PORTS +: PORTS] = act_read & ~cur_empty;
                // A set only counts when every port reads a real token together.
                if (&act_read && ~|cur_empty) begin
                    cnt_nxt = set_cnt + 1'b1;
                    if (set_cnt == CW'(NUM_OP - 1))
                        state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (act_wr && tag == grant && !out_full[grant]) begin
                    drain_done = 1'b1;
                    state_nxt  = IDLE;
                    rr_nxt     = TAG_WIDTH'(rr_next(int'(grant), FLUX));
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Result routing is independent of the arbitration state; bad tags are dropped.
    always_comb begin
        out_wr   = '0;
        out_data = {FLUX{act_out_data[PW-1:0]}};
        act_full = 1'b0;
        if (tag_ok) begin
            act_full    = out_full[tag];
            out_wr[tag] = act_wr & ~out_full[tag];
        end
    end

    assign busy = (state != IDLE);

`ifdef CSDF_SCHED_STATS_EN
    always_ff @(posedge ck or negedge rst) begin
        if (!rst)
            burst_cnt <= '0;
        else if (drain_done)
            burst_cnt[int'(grant)*16 +: 16] <= burst_cnt[int'(grant)*16 +: 16] + 16'd1;
    end
`endif

endmodule

// File: doc/csdf_flux_sched.md
Name: csdf_flux_sched

Overview:
- Round-robin flux scheduler placed in front of a shared multi-port accumulating CSDF actor.
- Selects one of FLUX input fluxes, each with PORTS FIFO read interfaces, and presents only that flux to the actor.
- Holds the grant for a complete NUM_OP-token burst and keeps it until the actor writes the tagged result.
- Demultiplexes the actor's tagged output word to per-flux output FIFOs, with per-flux back-pressure.

Parameters:
- PORTS, 2, input ports per flux (actor input ports).
- FLUX, 2, number of fluxes sharing the actor.
- WIDTH, 8, token width including tag.
- NUM_OP, 4, token sets per burst (actor firing length).
- TAG_WIDTH, $clog2(FLUX) (min 1), tag field, MSBs of output word.

Ports:
- ck  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset (0 = reset)
- in_data  in  WIDTH*PORTS*FLUX  flux-major, port-minor; port p of flux f at [(f*PORTS+p)*WIDTH +: WIDTH]
- in_empty  in  PORTS*FLUX  bit f*PORTS+p
- in_read  out  PORTS*FLUX  read strobes back to input FIFOs
- act_data  out  WIDTH*PORTS  granted flux's data to actor
- act_empty  out  PORTS  granted flux's empties; all 1 when not in GRANT
- act_read  in  PORTS  actor read strobes
- act_wr  in  1  actor output write
- act_out_data  in  WIDTH  {tag, payload} from actor
- act_full  out  1  back-pressure to actor
- out_full  in  FLUX  per-flux output FIFO full
- out_wr  out  FLUX  per-flux write
- out_data  out  (WIDTH-TAG_WIDTH)*FLUX  per-flux payload, tag stripped
- grant  out  TAG_WIDTH  current flux index (registered)
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE, grant=0, rr_ptr=0, set_cnt=0. Combinational outputs settle to in_read=0, out_wr=0, act_empty=all 1. The actor must share this reset; resetting mid-burst discards the burst.
- Ready(f) = all PORTS in_empty bits of flux f are 0.
- IDLE: search f = rr_ptr, rr_ptr+1, … (mod FLUX); take the first f with ready(f). Next cycle grant<=f, state<=GRANT, set_cnt<=0. If none is ready, stay in IDLE. Arbitration latency is one cycle.
- GRANT:
  - act_data/act_empty = slice of flux grant.
  - in_read[grant*PORTS+p] = act_read[p] & ~in_empty[grant*PORTS+p]; all other in_read = 0.
  - A set is consumed when every act_read bit is 1 and the granted flux is ready in the same cycle; set_cnt increments.
  - On the NUM_OP-th set (set_cnt==NUM_OP-1 & consume): state<=DRAIN.
  - Partial act_read (not all ports) is passed through but not counted.
- DRAIN: act_empty = all 1; all in_read = 0. Wait for act_wr & act_out_data tag==grant & ~out_full[grant]. Then state<=IDLE, rr_ptr<=grant+1 (wraps to 0 at FLUX).
- Output routing (any state): t = act_out_data[WIDTH-1 -: TAG_WIDTH].
  - act_full = out_full[t].
  - out_wr[t] = act_wr & ~out_full[t]; out_data slice t = low WIDTH-TAG_WIDTH bits; other out_wr = 0.
  - A tag >= FLUX is dropped (no out_wr).
- act_wr with tag != grant: routed normally; does not end DRAIN.
- act_wr with tag==grant during GRANT: routed; does not end the burst.
- act_full=1 in DRAIN: stay in DRAIN indefinitely.
- FLUX=1: grant fixed at 0; IDLE→GRANT→DRAIN→IDLE cycle still applies.
- Counter widths: set_cnt is $clog2(NUM_OP+1) bits; rr_ptr and grant are TAG_WIDTH bits.

Optional Feature:
- CSDF_SCHED_STATS_EN defined: adds output burst_cnt (16*FLUX bits). The counter for flux f increments by one (wraps at 2^16) whenever a DRAIN completes for f. Cleared by reset.
- Not defined: port and counters absent; all other behaviour identical.

Decomposition:
- Package csdf_sched_pkg: state enum (IDLE, GRANT, DRAIN), TAG_WIDTH and set-counter width functions, rr-next helper function.
- One sub-module rr_arbiter: FLUX-bit ready vector + rr_ptr in, one-hot/index + valid out, purely combinational.
- Routing mux and demux stay inline.

Test Plan:
- Single flux 1 ready (FLUX=2, NUM_OP=4) → grant=1 one cycle later. Exactly 4 all-port reads reach flux 1 and none reach flux 0. State moves to DRAIN after the 4th read and to IDLE after act_wr with tag=1; rr_ptr=0.
- Both fluxes continuously ready, rr_ptr=0 → grants alternate 0,1,0,1. No interleaving of reads between fluxes within a burst.
- out_full[0]=1 during DRAIN of flux 0 for 10 cycles → act_full=1, out_wr=0, state held in DRAIN. Release → out_wr[0] pulses once with payload = act_out_data[6:0].
- Flux 0 input goes empty mid-burst after 2 sets → act_empty shows empty, set_cnt holds at 2, no reads issued. Refill → burst completes after 2 more sets.
- rst driven low during GRANT with set_cnt=3 → immediate state=IDLE, grant=0, in_read=0. After rst=1, a fresh burst starts with set_cnt=0.
- STATS_EN: 3 completed bursts on flux 1 → burst_cnt[31:16]=3, burst_cnt[15:0]=0.
